// File: rtl/rename_retirement_unit.sv
// Retirement-side rename unit: maintains the retirement RAT, frees displaced physical
// registers and copies the RRAT back to the frontend RAT over several beats on recovery.
module rename_retirement_unit #(
  parameter int PHYSICAL_REGISTERS = 64,
  parameter int LOGICAL_REGISTERS  = 32,
  parameter int COMMIT_WIDTH       = 2,
  parameter int RESTORE_PER_CYCLE  = 8,
  localparam int PHY_REGS_BITS     = $clog2(PHYSICAL_REGISTERS),
  localparam int LOG_REGS_BITS     = $clog2(LOGICAL_REGISTERS)
) (
  input  logic                                              clk_i,
  input  logic                                              rstn_i,
  input  logic [COMMIT_WIDTH-1:0]                           commit_valid_i,
  output logic                                              commit_ready_o,
  input  logic [COMMIT_WIDTH-1:0]                           gl_use_dst_i,
  input  logic [COMMIT_WIDTH-1:0][LOG_REGS_BITS-1:0]        gl_log_dst_i,
  input  logic [COMMIT_WIDTH-1:0][PHY_REGS_BITS-1:0]        gl_new_phys_i,
  input  logic [COMMIT_WIDTH-1:0][PHY_REGS_BITS-1:0]        gl_old_phys_i,
  output logic [COMMIT_WIDTH-1:0]                           free_wr_en_o,
  output logic [COMMIT_WIDTH-1:0][PHY_REGS_BITS-1:0]        free_wr_reg_o,
  input  logic                                              recovery_req_i,
  output logic                                              recovery_busy_o,
  output logic                                              rat_restore_en_o,
  output logic [LOG_REGS_BITS-1:0]                          rat_restore_base_o,
  output logic [RESTORE_PER_CYCLE-1:0][PHY_REGS_BITS-1:0]   rat_restore_data_o,
  output logic                                              recovery_done_o,
  output logic [31:0]                                       retired_cnt_o
);

  localparam int BEATS     = LOGICAL_REGISTERS / RESTORE_PER_CYCLE;
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {RUN, RESTORE, DONE} state_t;

  state_t                  state, state_next;
  logic [BEAT_BITS-1:0]    beat, beat_next;
  logic                    last_beat;
  logic [COMMIT_WIDTH-1:0] accept;
  logic [COMMIT_WIDTH-1:0] frees;
  logic [31:0]             accept_cnt;
  logic [PHY_REGS_BITS-1:0] rrat [LOGICAL_REGISTERS];

  assign last_beat = (beat == BEAT_BITS'(BEATS - 1));

  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      RUN: begin
        if (recovery_req_i) begin
          state_next = RESTORE;
          beat_next  = '0;
        end
      end
      RESTORE: begin
        if (last_beat) begin
          state_next = DONE;
        end else begin
          beat_next = beat + BEAT_BITS'(1);
        end
      end
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= RUN;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  assign commit_ready_o   = (state == RUN);
  assign recovery_busy_o  = (state != RUN);
  assign rat_restore_en_o = (state == RESTORE);
  assign recovery_done_o  = (state == DONE);

  always_comb begin
    accept     = '0;
    frees      = '0;
    accept_cnt = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      accept[k] = commit_valid_i[k] & commit_ready_o;
      frees[k]  = accept[k] & gl_use_dst_i[k] & (gl_log_dst_i[k] != '0);
      if (accept[k]) accept_cnt = accept_cnt + 32'd1;
    end
  end

  // Later lanes are written last, so the youngest lane wins on a shared destination.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < LOGICAL_REGISTERS; i++) begin
        rrat[i] <= PHY_REGS_BITS'(i);
      end
    end else begin
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (frees[k]) rrat[gl_log_dst_i[k]] <= gl_new_phys_i[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      free_wr_en_o  <= '0;
      free_wr_reg_o <= '0;
      retired_cnt_o <= '0;
    end else begin
      free_wr_en_o  <= frees;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        free_wr_reg_o[k] <= frees[k] ? gl_old_phys_i[k] : '0;
      end
      retired_cnt_o <= retired_cnt_o + accept_cnt;
    end
  end

  always_comb begin
    rat_restore_base_o = '0;
    rat_restore_data_o = '0;
    if (rat_restore_en_o) begin
      rat_restore_base_o = LOG_REGS_BITS'(int'(beat) * RESTORE_PER_CYCLE);
      for (int unsigned i = 0; i < RESTORE_PER_CYCLE; i++) begin
        rat_restore_data_o[i] = rrat[LOG_REGS_BITS'(rat_restore_base_o + LOG_REGS_BITS'(i))];
      end
    end
  end

  logic [COMMIT_WIDTH-1:0] valid_plus_one;
  assign valid_plus_one = commit_valid_i + COMMIT_WIDTH'(1);

  a_lanes_contiguous: assert property (@(posedge clk_i) disable iff (!rstn_i)
    ((commit_valid_i & valid_plus_one) == '0))
    else $error("commit_valid_i lanes not contiguous from lane 0");

  a_no_commit_when_stalled: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !((|commit_valid_i) && !commit_ready_o))
    else $error("commit_valid_i asserted while commit_ready_o is low");

  a_recovery_only_in_run: assert property (@(posedge clk_i) disable iff (!rstn_i)
    recovery_req_i |-> (state == RUN))
    else $warning("recovery_req_i outside RUN ignored");

endmodule

// File: tb/tb_rename_retirement_unit.sv
// Directed plus random bench for rename_retirement_unit against a behavioural model.
module tb_rename_retirement_unit;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0]      valid, use_dst;
  logic [1:0][4:0] log_dst;
  logic [1:0][5:0] new_phys, old_phys;
  logic            req;
  logic            ready, busy, rs_en, done;
  logic [1:0]      fen;
  logic [1:0][5:0] freg;
  logic [4:0]      rs_base;
  logic [7:0][5:0] rs_data;
  logic [31:0]     cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_rrat [32];
  int          m_phase;      // 0 run, 1..4 restore beat+1, 5 done
  logic [1:0]  m_fen;
  logic [5:0]  m_freg [2];
  int unsigned m_cnt;

  rename_retirement_unit #(
    .PHYSICAL_REGISTERS(64),
    .LOGICAL_REGISTERS (32),
    .COMMIT_WIDTH      (2),
    .RESTORE_PER_CYCLE (8)
  ) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .commit_valid_i    (valid),
    .commit_ready_o    (ready),
    .gl_use_dst_i      (use_dst),
    .gl_log_dst_i      (log_dst),
    .gl_new_phys_i     (new_phys),
    .gl_old_phys_i     (old_phys),
    .free_wr_en_o      (fen),
    .free_wr_reg_o     (freg),
    .recovery_req_i    (req),
    .recovery_busy_o   (busy),
    .rat_restore_en_o  (rs_en),
    .rat_restore_base_o(rs_base),
    .rat_restore_data_o(rs_data),
    .recovery_done_o   (done),
    .retired_cnt_o     (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rrat[i] = i;
    m_phase = 0;
    m_fen   = '0;
    m_freg[0] = '0;
    m_freg[1] = '0;
    m_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    bit restoring;
    int base;
    restoring = (m_phase >= 1) && (m_phase <= 4);
    base = restoring ? (m_phase - 1) * 8 : 0;
    chk({tag, ".ready"}, 32'(ready), 32'(m_phase == 0));
    chk({tag, ".busy"},  32'(busy),  32'(m_phase != 0));
    chk({tag, ".rs_en"}, 32'(rs_en), 32'(restoring));
    chk({tag, ".done"},  32'(done),  32'(m_phase == 5));
    chk({tag, ".base"},  32'(rs_base), 32'(base));
    chk({tag, ".fen"},   32'(fen),   32'(m_fen));
    chk({tag, ".cnt"},   cnt, m_cnt);
    for (int k = 0; k < 2; k++) begin
      if (m_fen[k]) chk($sformatf("%s.freg%0d", tag, k), 32'(freg[k]), 32'(m_freg[k]));
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.data%0d", tag, i), 32'(rs_data[i]),
          restoring ? m_rrat[base + i] : 32'd0);
    end
  endtask

  task automatic idle_inputs();
    valid = '0; use_dst = '0; log_dst = '0; new_phys = '0; old_phys = '0; req = 1'b0;
  endtask

  task automatic cycle(input string tag, input logic [1:0] v, input logic [1:0] u,
                       input int l0, input int l1, input int n0, input int n1,
                       input int o0, input int o1, input bit r);
    int l [2]; int n [2]; int o [2];
    bit acc;
    l[0] = l0; l[1] = l1; n[0] = n0; n[1] = n1; o[0] = o0; o[1] = o1;
    valid = v; use_dst = u; req = r;
    for (int k = 0; k < 2; k++) begin
      log_dst[k]  = 5'(l[k]);
      new_phys[k] = 6'(n[k]);
      old_phys[k] = 6'(o[k]);
    end
    for (int k = 0; k < 2; k++) begin
      acc = v[k] && (m_phase == 0);
      m_fen[k]  = acc && u[k] && (l[k] != 0);
      m_freg[k] = m_fen[k] ? 6'(o[k]) : 6'd0;
      if (acc) m_cnt++;
    end
    for (int k = 0; k < 2; k++) if (m_fen[k]) m_rrat[l[k]] = n[k];
    if (m_phase == 0) m_phase = r ? 1 : 0;
    else if (m_phase == 5) m_phase = 0;
    else m_phase = m_phase + 1;
    @(posedge clk);
    #1;
    idle_inputs();
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int count);
    for (int i = 0; i < count; i++) cycle(tag, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rstn = 1'b1;
    #1;
    check_outputs("reset_release");

    cycle("t1_lane0", 2'b01, 2'b01, 5, 0, 40, 0, 5, 0, 1'b0);
    cycle("t2_shared", 2'b11, 2'b11, 7, 7, 41, 42, 7, 41, 1'b0);
    idle("t2_idle", 1);
    cycle("t3_log0", 2'b01, 2'b01, 0, 0, 33, 0, 9, 0, 1'b0);

    cycle("t4_req", 2'b01, 2'b01, 3, 0, 50, 0, 3, 0, 1'b1);
    idle("t4_restore", 6);

    cycle("t5_req", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    cycle("t5_req_busy", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    cycle("t5_req_busy", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    idle("t5_restore", 4);

    cycle("t6_req", 2'b11, 2'b11, 9, 10, 60, 61, 9, 10, 1'b1);
    idle("t6_beat", 2);
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_reset_mid");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check_outputs("t6_release");
    cycle("t6_req2", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    idle("t6_identity", 5);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] v;
      int nl;
      nl = $urandom_range(0, 2);
      v  = (m_phase != 0) ? 2'b00 : (nl == 0) ? 2'b00 : (nl == 1) ? 2'b01 : 2'b11;
      cycle("rand", v, 2'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 63), $urandom_range(0, 63),
            $urandom_range(0, 63), $urandom_range(0, 63), ($urandom_range(0, 11) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
